// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes,
// frame field widths and the default load address / IM capacity.
package im_loader_pkg;

   localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
   localparam int          IM_DEPTH     = 4096;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 16;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR_HI = 3'd1,
      S_HDR_LO = 3'd2,
      S_DATA   = 3'd3,
      S_CHK    = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_e;

endpackage

// File: rtl/im_loader_word_packer.sv
// Packs the payload byte stream into big-endian 32-bit words. The previous
// three bytes are held in a shift register; the fourth byte completes the
// word combinationally so the loader can register it on the same edge.
import im_loader_pkg::*;

module im_loader_word_packer (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                clr_i,
   input  logic                byte_en_i,
   input  logic [BYTE_W-1:0]   byte_i,
   output logic [WORD_W-1:0]   word_o,
   output logic                word_valid_o
);

   logic [1:0]  idx_q;
   logic [23:0] sr_q;

   // Byte index wraps naturally after the fourth byte; clear restarts a frame.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         idx_q <= 2'd0;
         sr_q  <= '0;
      end else if (clr_i) begin
         idx_q <= 2'd0;
         sr_q  <= '0;
      end else if (byte_en_i) begin
         idx_q <= idx_q + 2'd1;
         sr_q  <= {sr_q[15:0], byte_i};
      end
   end

   assign word_valid_o = byte_en_i && (idx_q == 2'd3);
   assign word_o       = {sr_q, byte_i};

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: takes a framed byte stream from the host link,
// writes packed words to the IM write port and holds the CPU meanwhile.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start, nothing loaded since reset
// S_HDR_HI | expecting word-count high byte
// S_HDR_LO | expecting word-count low byte, count range check
// S_DATA   | receiving payload bytes, one IM write per 4 bytes
// S_CHK    | expecting checksum byte (XOR of payload)
// S_DONE   | load finished with matching checksum
// S_ERR    | load aborted: count too large or checksum mismatch
import im_loader_pkg::*;

module im_loader #(
   parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
   parameter int          DEPTH     = IM_DEPTH
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               start_i,
   input  logic [BYTE_W-1:0]  in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic               im_we_o,
   output logic [31:0]        im_addr_o,
   output logic [WORD_W-1:0]  im_wdata_o,
   output logic               cpu_hold_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_e              state_q;
   logic [31:0]         addr_q;
   logic [WORD_W-1:0]   wdata_q;
   logic                we_q;
   logic                hold_q;
   logic                done_q;
   logic                err_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    words_q;
   logic [BYTE_W-1:0]   chk_q;

   logic                in_ready;
   logic                accept;
   logic                start_fire;
   logic [CNT_W-1:0]    cnt_full;
   logic [WORD_W-1:0]   pk_word;
   logic                pk_valid;

   // Ready decode. In DATA, ready drops once all N words have been packed so
   // the checksum byte is never taken while the last word is still being
   // strobed; the FSM moves to S_CHK on that strobe.
   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         S_HDR_HI, S_HDR_LO, S_CHK: in_ready = 1'b1;
         S_DATA:                    in_ready = (words_q != cnt_q);
         default:                   in_ready = 1'b0;
      endcase
   end

   assign accept     = in_valid_i && in_ready;
   assign start_fire = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                   (state_q == S_ERR));
   assign cnt_full   = {cnt_q[15:8], in_data_i};

   im_loader_word_packer u_packer (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .clr_i        (start_fire),
      .byte_en_i    (accept && (state_q == S_DATA)),
      .byte_i       (in_data_i),
      .word_o       (pk_word),
      .word_valid_o (pk_valid)
   );

   // Loader FSM, write port, address/word counters and running checksum.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         we_q    <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         words_q <= '0;
         chk_q   <= '0;
      end else begin
         we_q <= 1'b0;
         if (we_q) addr_q <= addr_q + 32'd4;
         unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_i) begin
                  state_q <= S_HDR_HI;
                  addr_q  <= BASE_ADDR;
                  hold_q  <= 1'b1;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  chk_q   <= '0;
                  words_q <= '0;
                  cnt_q   <= '0;
               end
            end
            S_HDR_HI: begin
               if (accept) begin
                  cnt_q[15:8] <= in_data_i;
                  state_q     <= S_HDR_LO;
               end
            end
            S_HDR_LO: begin
               if (accept) begin
                  cnt_q <= cnt_full;
                  if (cnt_full > DEPTH_C) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                     hold_q  <= 1'b0;
                  end else if (cnt_full == '0) begin
                     state_q <= S_CHK;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  chk_q <= chk_q ^ in_data_i;
                  if (pk_valid) begin
                     we_q    <= 1'b1;
                     wdata_q <= pk_word;
                     words_q <= words_q + 16'd1;
                  end
               end
               if (we_q && (words_q == cnt_q)) state_q <= S_CHK;
            end
            S_CHK: begin
               if (accept) begin
                  hold_q <= 1'b0;
                  if (in_data_i == chk_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o = in_ready;
   assign im_we_o    = we_q;
   assign im_addr_o  = addr_q;
   assign im_wdata_o = wdata_q;
   assign cpu_hold_o = hold_q;
   assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign done_o     = done_q;
   assign error_o    = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed + randomized bench for im_loader. Expected writes and outcome are
// derived from the frame contents: word i lands at BASE + 4*i, the load is
// good only when the count fits and CHK equals the XOR of all payload bytes.
module tb_im_loader;
   import im_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, im_we, cpu_hold, busy, done, error;
   logic [31:0] im_addr, im_wdata;

   int total = 0;
   int bad   = 0;
   logic [63:0] wr_q[$];

   im_loader dut (
      .clk_i      (clk),
      .reset_ni   (reset_n),
      .start_i    (start),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .im_we_o    (im_we),
      .im_addr_o  (im_addr),
      .im_wdata_o (im_wdata),
      .cpu_hold_o (cpu_hold),
      .busy_o     (busy),
      .done_o     (done),
      .error_o    (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (im_we === 1'b1) wr_q.push_back({im_addr, im_wdata});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "/in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "/im_we"},    32'(im_we),    32'd0);
      check({tag, "/cpu_hold"}, 32'(cpu_hold), 32'd0);
      check({tag, "/busy"},     32'(busy),     32'd0);
      check({tag, "/done"},     32'(done),     32'd0);
      check({tag, "/error"},    32'(error),    32'd0);
      check({tag, "/im_addr"},  im_addr,       32'h0000_3000);
      check({tag, "/im_wdata"}, im_wdata,      32'd0);
   endtask

   // Called at a negedge; returns at the negedge after the byte transferred.
   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int n = 0;
      if (rnd) while ($urandom_range(1, 0) == 0) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $error("FAIL send_timeout observed=ready_low expected=ready_high");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [7:0] xor_words(input logic [31:0] words[$]);
      logic [7:0] x = 8'h00;
      foreach (words[i]) x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
      return x;
   endfunction

   task automatic run_frame(input string tag, input logic [15:0] cnt, input logic [31:0] words[$],
                            input logic [7:0] chk, input bit rnd, input int mid_start,
                            input bit start_on_chk);
      logic [7:0] bytes[$];
      bit legal, exp_done;
      int n_exp;
      legal    = (int'(cnt) <= IM_DEPTH);
      exp_done = legal && (chk == xor_words(words));
      n_exp    = legal ? words.size() : 0;
      wr_q.delete();
      pulse_start();
      check({tag, "/start_hold"}, 32'(cpu_hold), 32'd1);
      check({tag, "/start_busy"}, 32'(busy),     32'd1);
      check({tag, "/start_done"}, 32'(done),     32'd0);
      check({tag, "/start_err"},  32'(error),    32'd0);
      check({tag, "/start_addr"}, im_addr,       32'h0000_3000);
      bytes.push_back(cnt[15:8]);
      bytes.push_back(cnt[7:0]);
      if (legal) begin
         foreach (words[i]) begin
            bytes.push_back(words[i][31:24]);
            bytes.push_back(words[i][23:16]);
            bytes.push_back(words[i][15:8]);
            bytes.push_back(words[i][7:0]);
         end
         bytes.push_back(chk);
      end
      for (int i = 0; i < bytes.size(); i++) begin
         if (i == mid_start) pulse_start();
         if (start_on_chk && i == bytes.size() - 1) start = 1'b1;
         send_byte(bytes[i], rnd);
         start = 1'b0;
      end
      repeat (4) @(negedge clk);
      check({tag, "/done"},     32'(done),     32'(exp_done));
      check({tag, "/error"},    32'(error),    32'(!exp_done));
      check({tag, "/hold"},     32'(cpu_hold), 32'd0);
      check({tag, "/busy"},     32'(busy),     32'd0);
      check({tag, "/in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "/n_writes"}, 32'(wr_q.size()), 32'(n_exp));
      for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
         check({tag, "/addr"}, wr_q[i][63:32], 32'h0000_3000 + 32'(4 * i));
         check({tag, "/data"}, wr_q[i][31:0],  words[i]);
      end
   endtask

   initial begin
      logic [31:0] w[$];
      logic [7:0]  x;
      int          k;

      // Reset values, then abort a load mid-DATA.
      repeat (3) @(negedge clk);
      check_reset("rst");
      reset_n = 1'b1;
      @(negedge clk);
      check_reset("idle");
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      check("t1/we_pre",   32'(im_we), 32'd1);
      check("t1/addr_pre", im_addr,    32'h0000_3000);
      check("t1/data_pre", im_wdata,   32'h1122_3344);
      reset_n = 1'b0;
      #1;
      check_reset("t1/abort");
      @(negedge clk);
      reset_n = 1'b1;
      wr_q.delete();
      repeat (10) @(negedge clk);
      check("t1/no_we", 32'(wr_q.size()), 32'd0);

      // Two-word frame; correct checksum for this payload is 0x20.
      w = '{32'h2401_0005, 32'h0000_0000};
      run_frame("t2", 16'd2, w, xor_words(w), 0, -1, 0);
      run_frame("t3", 16'd2, w, 8'h25, 0, -1, 0);

      // Count boundaries.
      w = '{};
      run_frame("t4_over", 16'h1001, w, 8'h00, 0, -1, 0);
      run_frame("t4_zero", 16'h0000, w, 8'h00, 0, -1, 0);

      // Three words with randomly gapped in_valid.
      w = '{$urandom, $urandom, $urandom};
      run_frame("t5", 16'd3, w, xor_words(w), 1, -1, 0);

      // start during DATA ignored; start alongside the CHK byte ignored.
      w = '{$urandom, $urandom};
      run_frame("t6_mid", 16'd2, w, xor_words(w), 0, 5, 1);
      // Start after DONE: new load from BASE_ADDR.
      w = '{$urandom};
      run_frame("t6_again", 16'd1, w, xor_words(w), 1, -1, 0);

      // Random frames with random checksum correctness.
      for (int r = 0; r < 4; r++) begin
         w = '{};
         k = $urandom_range(5, 1);
         for (int i = 0; i < k; i++) w.push_back($urandom);
         x = xor_words(w);
         if ($urandom_range(1, 0) == 1) x = x ^ 8'($urandom_range(255, 1));
         run_frame("rnd", 16'(k), w, x, 1, -1, 0);
      end

      // Full-capacity frame (N == DEPTH), last write at 0x6FFC.
      w = '{};
      for (int i = 0; i < IM_DEPTH; i++) w.push_back($urandom);
      run_frame("t4_full", 16'(IM_DEPTH), w, xor_words(w), 0, -1, 0);
      if (wr_q.size() > 0) check("t4_full/last_addr", wr_q[wr_q.size() - 1][63:32], 32'h0000_6FFC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
